// File: rtl/ps2_key_queue_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_queue_pkg
// Purpose : shared constants and types for the PS/2 key event queue.
//           Scan-code prefixes, prefix-FSM state encoding, key event layout
//           and a helper that packs an event word.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package ps2_key_queue_pkg;

   localparam logic [7:0] SC_EXT  = 8'hE0;   // extended-key prefix
   localparam logic [7:0] SC_BRK  = 8'hF0;   // break (release) prefix

   localparam int EVENT_W = 10;
   localparam int REL_BIT = 9;
   localparam int EXT_BIT = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXT    = 2'd1,
      ST_BRK    = 2'd2,
      ST_EXTBRK = 2'd3
   } kq_state_t;

   // Event word: {release, extended, code[7:0]}
   function automatic logic [EVENT_W-1:0] make_event(input logic       rel,
                                                     input logic       ext,
                                                     input logic [7:0] code);
      logic [EVENT_W-1:0] ev;
      ev          = '0;
      ev[REL_BIT] = rel;
      ev[EXT_BIT] = ext;
      ev[7:0]     = code;
      return ev;
   endfunction

endpackage

// File: rtl/ps2_key_queue_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Purpose : single-clock first-word-fall-through FIFO, parameterised by
//           width and depth (depth must be a power of two).
// Ports   : clock, reset (sync, active high)
//           push, wr_data          write side
//           pop, rd_data           read side; rd_data valid whenever !empty
//           count, full, empty     occupancy status
// Handshake: push is a request that is taken when !full, or when full and an
//            effective pop happens in the same cycle (slot is freed). pop is
//            taken only when !empty; a pop on empty is ignored.
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // When full, a same-cycle pop frees the head slot, which is exactly the
   // slot wr_ptr points at; the head word has already been consumed.
   assign do_push = push & (~full | do_pop);

   // Gate the head word so the output is all-zero while nothing is queued.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/ps2_key_queue.sv
// ---------------------------------------------------------------------------
// ps2_key_queue
// Purpose : turns raw PS/2 scan-code bytes into key events and queues them
//           for the processor. 0xE0 / 0xF0 prefixes become flags on the
//           event; a sticky flag reports events lost to a full queue.
// Ports   : clock, reset           single clock, sync active-high reset
//           key_strobe, key_byte   byte input; one accept per strobe rise
//           rd_en                  pop request (ignored when empty)
//           rd_data                {release, extended, code} at queue head
//           empty, full, count     queue status
//           overflow, ovf_clr      sticky drop flag and its clear pulse
//           fsm_state              prefix FSM state, for observation
// ---------------------------------------------------------------------------
module ps2_key_queue
   import ps2_key_queue_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int AW         = 4,
   parameter bit DROP_BREAK = 1'b0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               key_strobe,
   input  logic [7:0]         key_byte,
   input  logic               rd_en,
   output logic [EVENT_W-1:0] rd_data,
   output logic               empty,
   output logic               full,
   output logic [AW:0]        count,
   output logic               overflow,
   input  logic               ovf_clr,
   output kq_state_t          fsm_state
);

   kq_state_t          state, state_next;
   logic               strobe_q;
   logic               accept;
   logic               push_req;
   logic               ev_rel;
   logic               ev_ext;
   logic [EVENT_W-1:0] ev_word;
   logic               ovf_set;

   // A held strobe is accepted only on its first cycle.
   assign accept    = key_strobe & ~strobe_q;
   assign fsm_state = state;
   assign ev_word   = make_event(ev_rel, ev_ext, key_byte);

   always_ff @(posedge clock) begin
      if (reset) begin
         strobe_q <= 1'b0;
         state    <= ST_IDLE;
      end else begin
         strobe_q <= key_strobe;
         state    <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      push_req   = 1'b0;
      ev_rel     = 1'b0;
      ev_ext     = 1'b0;
      if (accept) begin
         unique case (state)
            ST_IDLE: begin
               if (key_byte == SC_EXT)      state_next = ST_EXT;
               else if (key_byte == SC_BRK) state_next = ST_BRK;
               else                         push_req   = 1'b1;
            end
            ST_EXT: begin
               if (key_byte == SC_BRK)      state_next = ST_EXTBRK;
               else if (key_byte == SC_EXT) state_next = ST_EXT;
               else begin
                  ev_ext     = 1'b1;
                  push_req   = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (key_byte == SC_BRK)      state_next = ST_BRK;
               else if (key_byte == SC_EXT) state_next = ST_EXTBRK;
               else begin
                  ev_rel     = 1'b1;
                  push_req   = ~DROP_BREAK;
                  state_next = ST_IDLE;
               end
            end
            ST_EXTBRK: begin
               if ((key_byte == SC_BRK) || (key_byte == SC_EXT)) begin
                  state_next = ST_EXTBRK;
               end else begin
                  ev_rel     = 1'b1;
                  ev_ext     = 1'b1;
                  push_req   = ~DROP_BREAK;
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (EVENT_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push_req),
      .wr_data (ev_word),
      .pop     (rd_en),
      .rd_data (rd_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // An event is lost only when full with no pop freeing a slot. When full
   // the queue is non-empty, so rd_en alone means an effective pop.
   assign ovf_set = push_req & full & ~rd_en;

   always_ff @(posedge clock) begin
      if (reset)        overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;   // set beats a coincident clear
      else if (ovf_clr) overflow <= 1'b0;
   end

endmodule

// File: tb/tb_ps2_key_queue.sv
module tb_ps2_key_queue;
   import ps2_key_queue_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        key_strobe = 1'b0;
   logic [7:0]  key_byte = 8'h00;
   logic        rd_en = 1'b0;
   logic        ovf_clr = 1'b0;

   logic [9:0]  rd_data,  rd_data_d;
   logic        empty,    empty_d;
   logic        full,     full_d;
   logic [AW:0] count,    count_d;
   logic        overflow, overflow_d;
   kq_state_t   fsm_state, fsm_state_d;

   logic [9:0]  exp_q[$];
   int          checks = 0;
   int          errors = 0;

   ps2_key_queue #(.DEPTH(DEPTH), .AW(AW), .DROP_BREAK(1'b0)) dut (
      .clock(clock), .reset(reset), .key_strobe(key_strobe), .key_byte(key_byte),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
      .overflow(overflow), .ovf_clr(ovf_clr), .fsm_state(fsm_state)
   );

   ps2_key_queue #(.DEPTH(DEPTH), .AW(AW), .DROP_BREAK(1'b1)) dut_drop (
      .clock(clock), .reset(reset), .key_strobe(key_strobe), .key_byte(key_byte),
      .rd_en(rd_en), .rd_data(rd_data_d), .empty(empty_d), .full(full_d), .count(count_d),
      .overflow(overflow_d), .ovf_clr(ovf_clr), .fsm_state(fsm_state_d)
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; key_strobe = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
      step(); step();
      reset = 1'b0;
      exp_q.delete();
   endtask

   // driver: present a byte for 'hold' cycles, then one idle cycle
   task automatic send_byte(input logic [7:0] b, input int hold);
      key_strobe = 1'b1;
      key_byte   = b;
      repeat (hold) step();
      key_strobe = 1'b0;
      step();
   endtask

   // scoreboard pop: compare head against the expected queue, then pop
   task automatic pop_check(input string name);
      logic [9:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, rd_data=%h", name, rd_data);
      end else begin
         exp = exp_q.pop_front();
         if (empty !== 1'b0 || rd_data !== exp) begin
            errors++;
            $display("FAIL %s: rd_data=%h empty=%b, expected rd_data=%h empty=0", name, rd_data, empty, exp);
         end
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++;
      if (count !== (AW+1)'(exp_q.size())) begin
         errors++;
         $display("FAIL %s_count: count=%0d expected %0d", name, count, exp_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || count !== '0 || overflow !== 1'b0 ||
          rd_data !== 10'h000 || fsm_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset: empty=%b full=%b count=%0d ovf=%b rd_data=%h state=%0d, expected 1 0 0 0 000 0",
                  empty, full, count, overflow, rd_data, fsm_state);
      end
   endtask

   task automatic test_held_strobe();
      do_reset();
      key_strobe = 1'b1;
      key_byte   = 8'h1C;
      checks++;
      if (empty !== 1'b1) begin
         errors++; $display("FAIL held_pre: empty=%b expected 1", empty);
      end
      step();                       // accept edge
      exp_q.push_back(10'h01C);
      checks++;
      if (empty !== 1'b0 || rd_data !== 10'h01C) begin
         errors++; $display("FAIL held_latency: empty=%b rd_data=%h expected 0 01C", empty, rd_data);
      end
      step(); step();               // strobe held 3 cycles in total
      key_strobe = 1'b0;
      step();
      checks++;
      if (count !== 5'd1) begin
         errors++; $display("FAIL held_count: count=%0d expected 1", count);
      end
      pop_check("held_pop");
      checks++;
      if (empty !== 1'b1) begin
         errors++; $display("FAIL held_drained: empty=%b expected 1", empty);
      end
   endtask

   task automatic test_ext_brk();
      do_reset();
      send_byte(8'hE0, 1);
      send_byte(8'hF0, 1);
      checks++;
      if (count !== '0 || fsm_state !== ST_EXTBRK) begin
         errors++; $display("FAIL prefix_only: count=%0d state=%0d expected 0 3", count, fsm_state);
      end
      send_byte(8'h75, 1);
      exp_q.push_back(10'h375);
      checks++;
      if (count !== 5'd1 || fsm_state !== ST_IDLE) begin
         errors++; $display("FAIL ext_brk_count: count=%0d state=%0d expected 1 0", count, fsm_state);
      end
      pop_check("ext_brk_pop");
   endtask

   task automatic test_drop_break();
      do_reset();
      send_byte(8'h1C, 1); exp_q.push_back(10'h01C);
      send_byte(8'hF0, 1);
      send_byte(8'h1C, 2); exp_q.push_back(10'h21C);
      checks++;
      if (count_d !== 5'd1 || rd_data_d !== 10'h01C || fsm_state_d !== ST_IDLE) begin
         errors++; $display("FAIL drop_break: count=%0d rd_data=%h state=%0d expected 1 01C 0",
                            count_d, rd_data_d, fsm_state_d);
      end
      checks++;
      if (count !== 5'd2) begin
         errors++; $display("FAIL keep_break_count: count=%0d expected 2", count);
      end
      pop_check("keep_break_pop0");
      pop_check("keep_break_pop1");
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i <= DEPTH; i++) begin
         send_byte(8'h10 + 8'(i), 1);
         if (i < DEPTH) exp_q.push_back({2'b00, 8'h10 + 8'(i)});
      end
      checks++;
      if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1 || rd_data !== 10'h010) begin
         errors++; $display("FAIL overflow: full=%b count=%0d ovf=%b head=%h expected 1 16 1 010",
                            full, count, overflow, rd_data);
      end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_clr: overflow=%b expected 0", overflow);
      end
   endtask

   // relies on the queue left full by test_overflow
   task automatic test_push_pop_full();
      logic [9:0] exp;
      exp = exp_q[0];
      key_strobe = 1'b1;
      key_byte   = 8'h55;
      rd_en      = 1'b1;
      checks++;
      if (rd_data !== exp) begin
         errors++; $display("FAIL full_pop_head: rd_data=%h expected %h", rd_data, exp);
      end
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(10'h055);
      key_strobe = 1'b0;
      rd_en      = 1'b0;
      step();
      checks++;
      if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
         errors++; $display("FAIL full_push_pop: count=%0d ovf=%b full=%b expected 16 0 1",
                            count, overflow, full);
      end
      for (int i = 0; i < DEPTH; i++) pop_check("full_drain");
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_byte(8'hF0, 1);
      checks++;
      if (fsm_state !== ST_BRK) begin
         errors++; $display("FAIL mid_brk_state: state=%0d expected 2", fsm_state);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      send_byte(8'h1C, 1);
      exp_q.push_back(10'h01C);
      pop_check("mid_reset_pop");
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++;
      if (count !== '0 || empty !== 1'b1 || rd_data !== 10'h000) begin
         errors++; $display("FAIL pop_empty: count=%0d empty=%b rd_data=%h expected 0 1 000",
                            count, empty, rd_data);
      end
   endtask

   task automatic test_back_to_back();
      logic       rel, ext;
      logic [7:0] code;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         rel  = 1'($urandom_range(0, 1));
         ext  = 1'($urandom_range(0, 1));
         code = 8'($urandom_range(0, 8'hDF));
         if (ext) send_byte(SC_EXT, $urandom_range(1, 3));
         if (rel) send_byte(SC_BRK, $urandom_range(1, 3));
         send_byte(code, $urandom_range(1, 3));
         exp_q.push_back({rel, ext, code});
      end
      checks++;
      if (count !== 5'd10) begin
         errors++; $display("FAIL b2b_count: count=%0d expected 10", count);
      end
      while (exp_q.size() > 0) pop_check("b2b_pop");
   endtask

   initial begin
      test_reset();
      test_held_strobe();
      test_ext_brk();
      test_drop_break();
      test_overflow();
      test_push_pop_full();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
